// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: M-channel valid/ready multiplexer with a one-word output register.
// MODE 0 routes the channel named by Select; MODE 1 arbitrates round-robin
// starting from an internal pointer that advances past each granted channel.
//
// Ports:
//   Clk      - clock, rising edge
//   Reset    - asynchronous, active-high; clears the output register and pointer
//   InData   - M channels of N bits, channel c at [c*N +: N]
//   InValid  - per-channel valid
//   InReady  - per-channel accept (combinational)
//   Select   - channel choice in MODE 0, ignored in MODE 1
//   OutData  - registered data of the last transfer
//   OutValid - OutData holds an unconsumed word
//   OutReady - downstream accepts OutData
//   Grant    - registered index of the channel held in OutData
module sel_pipe_mux #(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int MODE = 0,
  localparam int SW  = $clog2(M)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [M*N-1:0]  InData,
  input  logic [M-1:0]    InValid,
  output logic [M-1:0]    InReady,
  input  logic [SW-1:0]   Select,
  output logic [N-1:0]    OutData,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [SW-1:0]   Grant
);

  logic [N-1:0]  r_data;
  logic          r_valid;
  logic [SW-1:0] r_grant;
  logic [SW-1:0] r_ptr;

  logic          w_slot_free;
  logic          w_chosen_vld;
  logic [SW-1:0] w_chosen_idx;
  logic [N-1:0]  w_data;
  logic          w_xfer;
  logic [SW-1:0] w_ptr_next;

  assign w_slot_free = !r_valid || OutReady;

  // Channel choice. The round-robin scan reduces the index modulo M by a
  // single conditional subtract, so non-power-of-two M wraps at M, not 2^SW.
  always_comb begin
    w_chosen_vld = 1'b0;
    w_chosen_idx = '0;
    if (MODE == 0) begin
      if (int'(Select) < M) begin
        w_chosen_vld = 1'b1;
        w_chosen_idx = Select;
      end
    end else begin
      for (int unsigned k = 0; k < M; k++) begin
        int unsigned j;
        j = int'(r_ptr) + k;
        if (j >= M) j = j - M;
        if (!w_chosen_vld && InValid[SW'(j)]) begin
          w_chosen_vld = 1'b1;
          w_chosen_idx = SW'(j);
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int unsigned c = 0; c < M; c++) begin
      if (SW'(c) == w_chosen_idx) w_data = InData[c*N +: N];
    end
  end

  // In MODE 0 the selected channel sees ready even when it is not valid.
  always_comb begin
    InReady = '0;
    for (int unsigned c = 0; c < M; c++) begin
      InReady[c] = !Reset && w_slot_free && w_chosen_vld && (SW'(c) == w_chosen_idx);
    end
  end

  assign w_xfer     = |(InReady & InValid);
  assign w_ptr_next = (int'(w_chosen_idx) == M - 1) ? '0 : w_chosen_idx + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_xfer) begin
        r_data  <= w_data;
        r_grant <= w_chosen_idx;
        r_valid <= 1'b1;
        if (MODE == 1) r_ptr <= w_ptr_next;
      end else if (w_slot_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign OutData  = r_data;
  assign OutValid = r_valid;
  assign Grant    = r_grant;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Bench for sel_pipe_mux: four instances (MODE 0 M=4, MODE 1 M=4, MODE 0 M=3,
// MODE 1 M=3). Stimulus pushes hand-computed {grant,data} words into per-instance
// queues; a negedge monitor pops and compares whenever OutValid && OutReady.
module tb_sel_pipe_mux;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  // u0: MODE 0, M=4, N=32
  logic [127:0] d0; logic [3:0] v0, rdy0; logic [1:0] sel0, g0; logic [31:0] od0; logic ov0, or0;
  // u1: MODE 1, M=4, N=32
  logic [127:0] d1; logic [3:0] v1, rdy1; logic [1:0] sel1, g1; logic [31:0] od1; logic ov1, or1;
  // u2: MODE 0, M=3, N=8
  logic [23:0] d2; logic [2:0] v2, rdy2; logic [1:0] sel2, g2; logic [7:0] od2; logic ov2, or2;
  // u3: MODE 1, M=3, N=8
  logic [23:0] d3; logic [2:0] v3, rdy3; logic [1:0] sel3, g3; logic [7:0] od3; logic ov3, or3;

  sel_pipe_mux #(.N(32), .M(4), .MODE(0)) u0 (
    .Clk(Clk), .Reset(Reset), .InData(d0), .InValid(v0), .InReady(rdy0), .Select(sel0),
    .OutData(od0), .OutValid(ov0), .OutReady(or0), .Grant(g0));
  sel_pipe_mux #(.N(32), .M(4), .MODE(1)) u1 (
    .Clk(Clk), .Reset(Reset), .InData(d1), .InValid(v1), .InReady(rdy1), .Select(sel1),
    .OutData(od1), .OutValid(ov1), .OutReady(or1), .Grant(g1));
  sel_pipe_mux #(.N(8), .M(3), .MODE(0)) u2 (
    .Clk(Clk), .Reset(Reset), .InData(d2), .InValid(v2), .InReady(rdy2), .Select(sel2),
    .OutData(od2), .OutValid(ov2), .OutReady(or2), .Grant(g2));
  sel_pipe_mux #(.N(8), .M(3), .MODE(1)) u3 (
    .Clk(Clk), .Reset(Reset), .InData(d3), .InValid(v3), .InReady(rdy3), .Select(sel3),
    .OutData(od3), .OutValid(ov3), .OutReady(or3), .Grant(g3));

  int checks = 0;
  int errors = 0;

  logic [33:0] q0[$], q1[$];
  logic [9:0]  q2[$], q3[$];

  // Round-robin expectations: grant sequence and the valid pattern driven with it.
  logic [1:0] g1t [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd3};
  logic [3:0] v1t [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'h9, 4'h9, 4'h9};
  logic [1:0] g3t [6]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [2:0] v3t [6]  = '{3'h7, 3'h7, 3'h7, 3'h7, 3'h3, 3'h3};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (ov0 && or0) begin
      if (q0.size() == 0) check("u0 unexpected word", 64'({g0, od0}), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("u0 out", 64'({g0, od0}), 64'(q0.pop_front()));
    end
    if (ov1 && or1) begin
      if (q1.size() == 0) check("u1 unexpected word", 64'({g1, od1}), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("u1 out", 64'({g1, od1}), 64'(q1.pop_front()));
    end
    if (ov2 && or2) begin
      if (q2.size() == 0) check("u2 unexpected word", 64'({g2, od2}), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("u2 out", 64'({g2, od2}), 64'(q2.pop_front()));
    end
    if (ov3 && or3) begin
      if (q3.size() == 0) check("u3 unexpected word", 64'({g3, od3}), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("u3 out", 64'({g3, od3}), 64'(q3.pop_front()));
    end
  end

  initial begin
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    sel0 = '0; sel1 = '0; sel2 = '0; sel3 = '0;
    or0 = 1'b0; or1 = 1'b0; or2 = 1'b0; or3 = 1'b0;
    for (int c = 0; c < 4; c++) d1[c*32 +: 32] = 32'(256 + c);
    for (int c = 0; c < 3; c++) d3[c*8 +: 8] = 8'(8'hC0 + c);

    // Reset state with valid inputs present
    #1 Reset = 1'b1;
    v0 = 4'hF; v1 = 4'hF; v2 = 3'h7; v3 = 3'h7; sel0 = 2'd2;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1; or3 = 1'b1;
    #12;
    check("reset u0 OutValid", 64'(ov0), 64'(0));
    check("reset u0 OutData", 64'(od0), 64'(0));
    check("reset u0 Grant", 64'(g0), 64'(0));
    check("reset u0 InReady", 64'(rdy0), 64'(0));
    check("reset u1 InReady", 64'(rdy1), 64'(0));
    check("reset u3 OutValid", 64'(ov3), 64'(0));
    tick();
    Reset = 1'b0;
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;

    // MODE 0 basic transfer on channel 2
    sel0 = 2'd2; v0 = 4'b0100; d0[95:64] = 32'hDEAD_BEEF; or0 = 1'b1;
    #1 check("u0 ready sel2", 64'(rdy0), 64'(4'b0100));
    q0.push_back({2'd2, 32'hDEAD_BEEF});
    tick();
    check("u0 valid after xfer", 64'(ov0), 64'(1));
    check("u0 data after xfer", 64'(od0), 64'(32'hDEAD_BEEF));
    check("u0 grant after xfer", 64'(g0), 64'(2));

    // Backpressure for 3 cycles, Select wandering while held
    d0[95:64] = 32'h1111_2222; or0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel0 = (i == 0) ? 2'd1 : (i == 1) ? 2'd3 : 2'd0;
      #1;
      check("u0 bp ready", 64'(rdy0), 64'(0));
      check("u0 bp data", 64'(od0), 64'(32'hDEAD_BEEF));
      check("u0 bp grant", 64'(g0), 64'(2));
      check("u0 bp valid", 64'(ov0), 64'(1));
      tick();
    end
    sel0 = 2'd2; or0 = 1'b1;
    #1 check("u0 release ready", 64'(rdy0), 64'(4'b0100));
    q0.push_back({2'd2, 32'h1111_2222});
    tick();

    // Back-to-back across channels at full throughput
    sel0 = 2'd0; v0 = 4'b0001; d0[31:0] = 32'hA0A0_A0A0;
    #1 check("u0 ready sel0", 64'(rdy0), 64'(4'b0001));
    q0.push_back({2'd0, 32'hA0A0_A0A0});
    tick();
    sel0 = 2'd3; v0 = 4'b1000; d0[127:96] = 32'h3333_3333;
    #1 check("u0 ready sel3", 64'(rdy0), 64'(4'b1000));
    check("u0 sustained valid", 64'(ov0), 64'(1));
    q0.push_back({2'd3, 32'h3333_3333});
    tick();
    v0 = 4'b0000;
    #1 check("u0 ready without valid", 64'(rdy0), 64'(4'b1000));
    tick();
    check("u0 idle valid", 64'(ov0), 64'(0));
    check("u0 idle data kept", 64'(od0), 64'(32'h3333_3333));
    check("u0 idle grant kept", 64'(g0), 64'(3));

    // Hold a word under backpressure, then reset mid-cycle
    sel0 = 2'd2; v0 = 4'b0100; d0[95:64] = 32'h5555_5555; or0 = 1'b0;
    tick();
    v0 = 4'b0000;
    check("u0 held before reset", 64'(ov0), 64'(1));
    #1 Reset = 1'b1;
    #1;
    check("u0 async reset valid", 64'(ov0), 64'(0));
    check("u0 async reset data", 64'(od0), 64'(0));
    check("u0 async reset grant", 64'(g0), 64'(0));
    check("u0 async reset ready", 64'(rdy0), 64'(0));
    Reset = 1'b0;
    tick();
    sel0 = 2'd1; v0 = 4'b0010; d0[63:32] = 32'h7777_7777; or0 = 1'b1;
    #1 check("u0 post-reset ready", 64'(rdy0), 64'(4'b0010));
    q0.push_back({2'd1, 32'h7777_7777});
    tick();
    v0 = 4'b0000;
    tick();

    // MODE 0, M=3: out-of-range select
    sel2 = 2'd3; v2 = 3'b111; d2 = 24'h5A_A5_3C; or2 = 1'b1;
    #1 check("u2 ready sel3", 64'(rdy2), 64'(0));
    tick();
    check("u2 no valid sel3", 64'(ov2), 64'(0));
    sel2 = 2'd1;
    #1 check("u2 ready sel1", 64'(rdy2), 64'(3'b010));
    q2.push_back({2'd1, 8'hA5});
    tick();
    v2 = 3'b000; sel2 = 2'd3;
    tick();

    // MODE 1, M=4: rotation then sparse pattern around the wrap
    or1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v1 = v1t[i];
      #1 check("u1 rr ready", 64'(rdy1), 64'(4'b0001 << g1t[i]));
      q1.push_back({g1t[i], 32'(256 + int'(g1t[i]))});
      tick();
    end
    v1 = 4'b0000;
    #1 check("u1 no valid ready", 64'(rdy1), 64'(0));
    tick();

    // MODE 1, M=3: index must wrap at 3
    or3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v3 = v3t[i];
      #1 check("u3 rr ready", 64'(rdy3), 64'(3'b001 << g3t[i]));
      q3.push_back({g3t[i], 8'(8'hC0 + int'(g3t[i]))});
      tick();
    end
    v3 = 3'b000;
    tick();
    tick();

    check("u0 queue drained", 64'(q0.size()), 64'(0));
    check("u1 queue drained", 64'(q1.size()), 64'(0));
    check("u2 queue drained", 64'(q2.size()), 64'(0));
    check("u3 queue drained", 64'(q3.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_pipe_mux.md
SEL_PIPE_MUX -- requirements
Module: sel_pipe_mux

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width per channel (N >= 1).
REQ-002 The block SHALL have parameter M, default 4, giving the input channel count (M >= 2).
REQ-003 The block SHALL have parameter MODE, default 0: 0 = explicit select, 1 = round-robin.
REQ-004 The block SHALL have a derived local parameter SW = clog2(M), giving the select and grant width.
REQ-005 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port InData, input, M*N bits: channel c occupies bits [c*N+N-1 : c*N].
REQ-008 Port InValid, input, M bits: per-channel data-valid.
REQ-009 Port InReady, output, M bits: per-channel accept, combinational.
REQ-010 Port Select, input, SW bits: channel choice in MODE 0; ignored in MODE 1.
REQ-011 Port OutData, output, N bits: registered selected data.
REQ-012 Port OutValid, output, 1 bit: OutData holds an unconsumed word.
REQ-013 Port OutReady, input, 1 bit: the downstream consumer accepts OutData.
REQ-014 Port Grant, output, SW bits: registered index of the channel whose word is in OutData.

Function
REQ-015 Slot free SHALL equal (!OutValid || OutReady).
REQ-016 In MODE 0, the chosen channel SHALL be Select when Select < M; when Select >= M, no channel is chosen and InReady is all zeros.
REQ-017 In MODE 1, the chosen channel SHALL be the first c with InValid[c] = 1, scanning Ptr, Ptr+1, ... modulo M; if no channel is valid, none is chosen.
REQ-018 InReady[c] SHALL be 1 only when slot free = 1 and c is the chosen channel; all other bits SHALL be 0.
REQ-019 A transfer SHALL occur on a clock edge where InValid[chosen] && InReady[chosen] = 1.
REQ-020 On a transfer, OutData <= chosen channel's data, Grant <= chosen index, OutValid <= 1; the latency is exactly 1 cycle.
REQ-021 With slot free and no transfer, OutValid SHALL go to 0, and OutData and Grant SHALL keep their values.
REQ-022 While OutValid && !OutReady, OutData, Grant and OutValid SHALL hold stable, and InReady SHALL be all zeros (backpressure).
REQ-023 A simultaneous consume and transfer SHALL sustain full throughput: one word per cycle, with OutValid remaining 1.
REQ-024 Round-robin pointer Ptr (SW bits, MODE 1 only): on a transfer, Ptr <= (chosen + 1) mod M, wrapping from M-1 to 0; otherwise Ptr holds.
REQ-025 A Select change while a word is held SHALL NOT alter OutData or Grant.
REQ-026 When M is not a power of two, MODE 1 index arithmetic SHALL wrap at M, never at 2^SW.
REQ-027 The block SHALL not drop or duplicate data: every transfer appears exactly once on Out with OutValid && OutReady.

Reset
REQ-028 While Reset = 1, the outputs SHALL be OutValid = 0, OutData = 0, Grant = 0, and Ptr SHALL be 0, regardless of Clk.
REQ-029 While Reset = 1, InReady SHALL be all zeros.
REQ-030 Reset asserted mid-operation SHALL discard any held word; the first transfer after deassertion follows REQ-019 from the REQ-028 state.

Verification
REQ-031 MODE 0, M=4, N=32, Select=2, InValid=4'b0100, ch2=0xDEADBEEF, OutReady=1 -> InReady=4'b0100; next cycle OutValid=1, OutData=0xDEADBEEF, Grant=2.
REQ-032 MODE 0, Select=2 held, OutReady=0 for 3 cycles after a transfer -> OutData and Grant hold, InReady=0000; OutReady=1 -> next word accepted in the same cycle.
REQ-033 MODE 0, M=3, Select=3, all InValid=1 -> InReady=000 and OutValid stays 0.
REQ-034 MODE 1, M=4, all InValid=1, OutReady=1 for 6 cycles -> Grant sequence 0,1,2,3,0,1.
REQ-035 MODE 1, M=4, InValid=4'b1001 with Ptr=1 -> channel 3 granted, then channel 0; Ptr wraps 0->1.
REQ-036 Reset pulse while OutValid=1 and OutReady=0 -> OutValid=0, OutData=0, Grant=0 immediately, with no clock edge needed.
